// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses as short or long and keeps a 4-bit LED press counter.
// Optional auto-repeat while held long is enabled by defining PRESS_REPEAT_EN.
module btn_press_classifier #(
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       debounce,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       pressed,
   output logic [3:0] led_driver
);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
   } state_e;

   localparam logic [25:0] HOLD_LAST = 26'(LONG_CYCLES - 1);

   state_e      state_q, state_d;
   logic [25:0] hold_cnt_q, hold_cnt_d;
   logic        short_pulse_q, short_pulse_d;
   logic        long_pulse_q, long_pulse_d;
   logic        pressed_q, pressed_d;
   logic [3:0]  led_q, led_d;

`ifdef PRESS_REPEAT_EN
   localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      short_pulse_d = 1'b0;
      long_pulse_d  = 1'b0;
      led_d         = led_q;
`ifdef PRESS_REPEAT_EN
      rep_cnt_d     = rep_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (debounce) begin
               state_d    = PRESSED;
               hold_cnt_d = 26'd1;
            end
         end
         PRESSED: begin
            if (!debounce) begin
               short_pulse_d = 1'b1;
               led_d         = led_q + 4'd1;
               state_d       = IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               long_pulse_d = 1'b1;
               led_d        = '0;
`ifdef PRESS_REPEAT_EN
               rep_cnt_d    = '0;
`endif
               state_d      = LONG_HELD;
            end else begin
               hold_cnt_d = hold_cnt_q + 26'd1;
            end
         end
         LONG_HELD: begin
            if (!debounce) begin
               state_d = IDLE;
            end
`ifdef PRESS_REPEAT_EN
            else if (rep_cnt_q == REP_LAST) begin
               short_pulse_d = 1'b1;
               led_d         = led_q + 4'd1;
               rep_cnt_d     = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      pressed_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         short_pulse_q <= 1'b0;
         long_pulse_q  <= 1'b0;
         pressed_q     <= 1'b0;
         led_q         <= '0;
`ifdef PRESS_REPEAT_EN
         rep_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         short_pulse_q <= short_pulse_d;
         long_pulse_q  <= long_pulse_d;
         pressed_q     <= pressed_d;
         led_q         <= led_d;
`ifdef PRESS_REPEAT_EN
         rep_cnt_q     <= rep_cnt_d;
`endif
      end
   end

   assign short_pulse = short_pulse_q;
   assign long_pulse  = long_pulse_q;
   assign pressed     = pressed_q;
   assign led_driver  = led_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench for btn_press_classifier: the driver queues expected pulses, a monitor checks them.
module tb_btn_press_classifier;

   localparam int LONG = 8;
   localparam int REP  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       debounce;
   logic       short_pulse;
   logic       long_pulse;
   logic       pressed;
   logic [3:0] led_driver;

   typedef struct {
      bit         is_long;
      logic [3:0] led;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         vec_cnt = 0;
   int         err_cnt = 0;
   logic [3:0] exp_led = 4'h0;

   btn_press_classifier #(
      .LONG_CYCLES  (LONG),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .debounce   (debounce),
      .short_pulse(short_pulse),
      .long_pulse (long_pulse),
      .pressed    (pressed),
      .led_driver (led_driver)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the head of the scoreboard in kind, LED value and edge.
   always @(negedge clk) begin
      if (short_pulse || long_pulse) begin
         exp_t e;
         vec_cnt++;
         if (short_pulse && long_pulse) begin
            err_cnt++;
            $display("FAIL both_pulses cyc=%0d short=%b long=%b want at most one", cyc, short_pulse, long_pulse);
         end else if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_pulse cyc=%0d short=%b long=%b led=%0d want no pulse",
                     cyc, short_pulse, long_pulse, led_driver);
         end else begin
            e = sb.pop_front();
            if (e.is_long != long_pulse || e.led !== led_driver || e.cyc != cyc) begin
               err_cnt++;
               $display("FAIL pulse got long=%b led=%0d cyc=%0d want long=%b led=%0d cyc=%0d",
                        long_pulse, led_driver, cyc, e.is_long, e.led, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      vec_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic push(bit is_long, logic [3:0] led, int c);
      exp_t e;
      e.is_long = is_long;
      e.led     = led;
      e.cyc     = c;
      sb.push_back(e);
   endtask

   // Drive nh high samples then nl low samples; queue the pulses that press must produce.
   task automatic press(int nh, int nl);
      int e0;
      e0 = cyc + 1;
      if (nh < LONG) begin
         exp_led = exp_led + 4'd1;
         push(1'b0, exp_led, e0 + nh);
      end else begin
         exp_led = 4'h0;
         push(1'b1, 4'h0, e0 + LONG - 1);
`ifdef PRESS_REPEAT_EN
         for (int t = e0 + LONG - 1 + REP; t <= e0 + nh - 1; t += REP) begin
            exp_led = exp_led + 4'd1;
            push(1'b0, exp_led, t);
         end
`endif
      end
      debounce = 1'b1;
      for (int i = 0; i < nh; i++) begin
         step();
         if (i == 0) chk("pressed_rise", {31'd0, pressed}, 32'd1);
      end
      debounce = 1'b0;
      for (int i = 0; i < nl; i++) begin
         step();
         if (i == 0) begin
            chk("pressed_fall", {31'd0, pressed}, 32'd0);
            chk("led_after", {28'd0, led_driver}, {28'd0, exp_led});
         end
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      debounce = 1'b0;
      step();
      step();
      exp_led = 4'h0;
      chk("rst_pressed", {31'd0, pressed}, 32'd0);
      chk("rst_led", {28'd0, led_driver}, 32'd0);
      chk("rst_short", {31'd0, short_pulse}, 32'd0);
      chk("rst_long", {31'd0, long_pulse}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      debounce = 1'b0;
      do_reset();

      press(3, 2);

      do_reset();
      for (int i = 0; i < 17; i++) press(2, 2);
      chk("led_wrap", {28'd0, led_driver}, 32'd1);

      press(7, 2);
      press(8, 3);
      chk("led_long_zero", {28'd0, led_driver}, 32'd0);

      press(20, 2);
`ifdef PRESS_REPEAT_EN
      chk("led_repeat", {28'd0, led_driver}, 32'd3);
`else
      chk("led_no_repeat", {28'd0, led_driver}, 32'd0);
`endif

      press(2, 2);
      debounce = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_led = 4'h0;
      chk("midrst_pressed", {31'd0, pressed}, 32'd0);
      chk("midrst_led", {28'd0, led_driver}, 32'd0);
      chk("midrst_pulses", {30'd0, short_pulse, long_pulse}, 32'd0);
      press(8, 2);

      press(1, 1);
      press(1, 3);
      chk("led_adjacent", {28'd0, led_driver}, 32'd2);

      step();
      step();
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
